// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the MIPS bus decoder
// Contents: FSM state enum, default slave page numbers, page-field width helper.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [23:0] DMEM_PAGE = 24'h000000;
    localparam logic [23:0] IO1_PAGE  = 24'h000008;
    localparam logic [23:0] IO2_PAGE  = 24'h000009;
    localparam logic [23:0] IO3_PAGE  = 24'h00000A;

    // Width of the page field compared against the page table.
    function automatic int page_w(input int addr_w, input int page_bits);
        return addr_w - page_bits;
    endfunction

endpackage

// File: rtl/mips_bus_decoder_if.sv
// rtl/mips_bus_decoder_if.sv - core-side and slave-side bus signals of the decoder
// Master side: req/we/addr/wdata/err_clr out, rdata/ready/err/busy/err_valid/err_addr in;
// it also models the slaves (s_rdata/s_ready out, s_sel/s_we/s_addr/s_wdata in).
// Slave modport is the decoder's view.
interface mips_bus_decoder_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic                         req;
    logic                         we;
    logic [ADDR_W-1:0]            addr;
    logic [DATA_W-1:0]            wdata;
    logic [DATA_W-1:0]            rdata;
    logic                         ready;
    logic                         err;
    logic                         busy;
    logic                         err_valid;
    logic [ADDR_W-1:0]            err_addr;
    logic                         err_clr;
    logic [NUM_SLAVES-1:0]        s_sel;
    logic                         s_we;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ready;

    modport slave (
        input  req, we, addr, wdata, err_clr, s_rdata, s_ready,
        output rdata, ready, err, busy, err_valid, err_addr,
               s_sel, s_we, s_addr, s_wdata
    );

    modport master (
        output req, we, addr, wdata, err_clr, s_rdata, s_ready,
        input  rdata, ready, err, busy, err_valid, err_addr,
               s_sel, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/mips_page_match.sv
// rtl/mips_page_match.sv - page-table compare with lowest-index priority
// Ports: page (in) page field of the address; hit (out) any entry matched;
// onehot (out) select of the winning entry; idx (out) binary index of the winner.
module mips_page_match
    import mips_bus_pkg::*;
#(
    parameter int                            NUM_SLAVES  = 4,
    parameter int                            PAGE_W      = 24,
    parameter int                            IDX_W       = 2,
    parameter logic [NUM_SLAVES*PAGE_W-1:0]  SLAVE_PAGES = {IO3_PAGE, IO2_PAGE, IO1_PAGE, DMEM_PAGE}
) (
    input  logic [PAGE_W-1:0]     page,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] onehot,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the highest index down so the lowest matching entry is
    // written last and wins when table entries overlap.
    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (page == SLAVE_PAGES[i*PAGE_W +: PAGE_W]) begin
                hit       = 1'b1;
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_bus_decoder.sv
// rtl/mips_bus_decoder.sv - registered memory-mapped bus decoder for the MIPS SoC
// Ports: clk, rst (async active-high); bus (slave modport): core request
// req/we/addr/wdata, completion rdata/ready/err/busy, sticky error
// err_valid/err_addr/err_clr, slave side s_sel/s_we/s_addr/s_wdata/s_rdata/s_ready.
module mips_bus_decoder
    import mips_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PAGE_BITS  = 8,
    parameter logic [NUM_SLAVES*(ADDR_W-PAGE_BITS)-1:0] SLAVE_PAGES =
        {IO3_PAGE, IO2_PAGE, IO1_PAGE, DMEM_PAGE},
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    mips_bus_decoder_if.slave bus
);

    localparam int PAGE_W = page_w(ADDR_W, PAGE_BITS);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT);

    state_t                state, state_n;
    logic [NUM_SLAVES-1:0] s_sel, s_sel_n;
    logic                  s_we, s_we_n;
    logic [ADDR_W-1:0]     s_addr, s_addr_n;
    logic [DATA_W-1:0]     s_wdata, s_wdata_n;
    logic [DATA_W-1:0]     rdata, rdata_n;
    logic                  err_valid, err_valid_n;
    logic [ADDR_W-1:0]     err_addr, err_addr_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      sel_idx, sel_idx_n;

    logic                  hit;
    logic [NUM_SLAVES-1:0] hit_onehot;
    logic [IDX_W-1:0]      hit_idx;
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_rdata;

    mips_page_match #(
        .NUM_SLAVES  (NUM_SLAVES),
        .PAGE_W      (PAGE_W),
        .IDX_W       (IDX_W),
        .SLAVE_PAGES (SLAVE_PAGES)
    ) u_match (
        .page   (bus.addr[ADDR_W-1:PAGE_BITS]),
        .hit    (hit),
        .onehot (hit_onehot),
        .idx    (hit_idx)
    );

    // Only the selected slave's ready/data matter; other slaves are ignored.
    assign sel_ready = bus.s_ready[sel_idx];
    assign sel_rdata = bus.s_rdata[sel_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s_sel     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            rdata     <= '0;
            err_valid <= 1'b0;
            err_addr  <= '0;
            cnt       <= '0;
            sel_idx   <= '0;
        end else begin
            state     <= state_n;
            s_sel     <= s_sel_n;
            s_we      <= s_we_n;
            s_addr    <= s_addr_n;
            s_wdata   <= s_wdata_n;
            rdata     <= rdata_n;
            err_valid <= err_valid_n;
            err_addr  <= err_addr_n;
            cnt       <= cnt_n;
            sel_idx   <= sel_idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        s_sel_n     = s_sel;
        s_we_n      = s_we;
        s_addr_n    = s_addr;
        s_wdata_n   = s_wdata;
        rdata_n     = rdata;
        err_valid_n = err_valid;
        err_addr_n  = err_addr;
        cnt_n       = cnt;
        sel_idx_n   = sel_idx;

        if (bus.err_clr) begin
            err_valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (bus.req) begin
                    s_addr_n  = bus.addr;
                    s_we_n    = bus.we;
                    s_wdata_n = bus.wdata;
                    cnt_n     = '0;
                    if (hit) begin
                        s_sel_n   = hit_onehot;
                        sel_idx_n = hit_idx;
                        state_n   = ACCESS;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    if (!s_we) begin
                        rdata_n = sel_rdata;
                    end
                    s_sel_n = '0;
                    s_we_n  = 1'b0;
                    state_n = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    s_sel_n = '0;
                    s_we_n  = 1'b0;
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            ERR: begin
                s_we_n = 1'b0;
                // A clear landing with a new error lets the new error become
                // the first one recorded.
                if (!err_valid || bus.err_clr) begin
                    err_valid_n = 1'b1;
                    err_addr_n  = s_addr;
                end
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.ready     = (state == RESP);
    assign bus.err       = (state == ERR);
    assign bus.busy      = (state != IDLE);
    assign bus.rdata     = rdata;
    assign bus.err_valid = err_valid;
    assign bus.err_addr  = err_addr;
    assign bus.s_sel     = s_sel;
    assign bus.s_we      = s_we;
    assign bus.s_addr    = s_addr;
    assign bus.s_wdata   = s_wdata;

endmodule

// File: tb/tb_mips_bus_decoder.sv
// tb/tb_mips_bus_decoder.sv - scoreboard bench for mips_bus_decoder
module tb_mips_bus_decoder;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    mips_bus_decoder_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

    mips_bus_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.req   = 1'b1;
        bus.addr  = a;
        bus.we    = w;
        bus.wdata = d;
    endtask

    task automatic expect_resp(input logic is_err, input logic [31:0] rd);
        exp_t e;
        e.is_err = is_err;
        e.rdata  = rd;
        sb_q.push_back(e);
    endtask

    // Monitor: every ready/err pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("ready_err_exclusive", {63'd0, bus.ready & bus.err}, 64'd0);
            chk("sel_onehot", {63'd0, $countones(bus.s_sel) > 1}, 64'd0);
            if (bus.ready || bus.err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, bus.ready, bus.err}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_kind", {63'd0, bus.err}, {63'd0, e.is_err});
                    if (!e.is_err) begin
                        chk("sb_rdata", {32'd0, bus.rdata}, {32'd0, e.rdata});
                    end
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req       = 1'b0;
        bus.we        = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.err_clr   = 1'b0;
        bus.s_ready   = '0;
        bus.s_rdata   = {32'hCAFEF00D, 32'h22222222, 32'hDEADBEEF, 32'h11110000};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_sel", {60'd0, bus.s_sel}, 64'd0);
        chk("rst_rdata", {32'd0, bus.rdata}, 64'd0);
        chk("rst_err_valid", {63'd0, bus.err_valid}, 64'd0);
        chk("rst_err_addr", {32'd0, bus.err_addr}, 64'd0);
        chk("rst_s_addr", {32'd0, bus.s_addr}, 64'd0);
        rst = 1'b0;
        step();

        // Zero-wait read from slave 1.
        issue(32'h0000_0804, 1'b0, 32'h0);
        bus.s_ready = 4'b0010;
        expect_resp(1'b0, 32'hDEADBEEF);
        step();
        bus.req = 1'b0;
        chk("rd_sel_c1", {60'd0, bus.s_sel}, 64'h2);
        chk("rd_busy_c1", {63'd0, bus.busy}, 64'd1);
        step();
        chk("rd_ready_c2", {63'd0, bus.ready}, 64'd1);
        chk("rd_rdata_c2", {32'd0, bus.rdata}, 64'hDEADBEEF);
        step();
        chk("rd_busy_c3", {63'd0, bus.busy}, 64'd0);
        bus.s_ready = '0;

        // Write to slave 0 with three wait states.
        issue(32'h0000_0010, 1'b1, 32'h12345678);
        expect_resp(1'b0, 32'hDEADBEEF);
        for (int k = 1; k <= 4; k++) begin
            step();
            bus.req = 1'b0;
            chk("wr_s_we", {63'd0, bus.s_we}, 64'd1);
            chk("wr_s_wdata", {32'd0, bus.s_wdata}, 64'h12345678);
            chk("wr_sel", {60'd0, bus.s_sel}, 64'h1);
            if (k == 4) bus.s_ready = 4'b0001;
        end
        step();
        chk("wr_ready_c5", {63'd0, bus.ready}, 64'd1);
        chk("wr_rdata_kept", {32'd0, bus.rdata}, 64'hDEADBEEF);
        chk("wr_we_dropped", {63'd0, bus.s_we}, 64'd0);
        bus.s_ready = '0;
        step();

        // Unmapped access.
        issue(32'h0000_0F00, 1'b0, 32'h0);
        expect_resp(1'b1, 32'h0);
        step();
        bus.req = 1'b0;
        chk("um_err_c1", {63'd0, bus.err}, 64'd1);
        chk("um_sel", {60'd0, bus.s_sel}, 64'd0);
        step();
        chk("um_err_valid", {63'd0, bus.err_valid}, 64'd1);
        chk("um_err_addr", {32'd0, bus.err_addr}, 64'h0F00);

        // Clear, then time out on slave 2.
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("clr_err_valid", {63'd0, bus.err_valid}, 64'd0);
        chk("clr_err_addr_kept", {32'd0, bus.err_addr}, 64'h0F00);
        issue(32'h0000_0900, 1'b0, 32'h0);
        expect_resp(1'b1, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            bus.req = 1'b0;
            chk("to_sel_held", {60'd0, bus.s_sel}, 64'h4);
        end
        step();
        chk("to_err", {63'd0, bus.err}, 64'd1);
        chk("to_sel_dropped", {60'd0, bus.s_sel}, 64'd0);
        step();
        chk("to_err_valid", {63'd0, bus.err_valid}, 64'd1);
        chk("to_err_addr", {32'd0, bus.err_addr}, 64'h0900);

        // Second error keeps the first address.
        issue(32'h0000_0F04, 1'b0, 32'h0);
        expect_resp(1'b1, 32'h0);
        step();
        bus.req = 1'b0;
        chk("e2_err", {63'd0, bus.err}, 64'd1);
        step();
        chk("e2_err_addr_kept", {32'd0, bus.err_addr}, 64'h0900);

        // Clear coinciding with a new error: capture wins.
        issue(32'h0000_0F08, 1'b0, 32'h0);
        expect_resp(1'b1, 32'h0);
        step();
        bus.req     = 1'b0;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("e3_err_valid", {63'd0, bus.err_valid}, 64'd1);
        chk("e3_err_addr", {32'd0, bus.err_addr}, 64'h0F08);

        // Busy req and unselected ready are ignored.
        issue(32'h0000_0A20, 1'b0, 32'h0);
        expect_resp(1'b0, 32'hCAFEF00D);
        step();
        bus.req     = 1'b1;
        bus.addr    = 32'h0000_0804;
        bus.s_ready = 4'b0001;
        chk("ig_sel_c1", {60'd0, bus.s_sel}, 64'h8);
        step();
        bus.req     = 1'b0;
        chk("ig_sel_c2", {60'd0, bus.s_sel}, 64'h8);
        chk("ig_s_addr", {32'd0, bus.s_addr}, 64'h0A20);
        bus.s_ready = 4'b1001;
        step();
        chk("ig_ready", {63'd0, bus.ready}, 64'd1);
        chk("ig_rdata", {32'd0, bus.rdata}, 64'hCAFEF00D);
        bus.s_ready = '0;
        step();
        chk("ig_idle", {63'd0, bus.busy}, 64'd0);
        step();
        chk("ig_not_queued", {63'd0, bus.busy}, 64'd0);

        // Reset in the middle of an access.
        issue(32'h0000_0010, 1'b0, 32'h0);
        step();
        bus.req = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mr_sel", {60'd0, bus.s_sel}, 64'd0);
        chk("mr_busy", {63'd0, bus.busy}, 64'd0);
        chk("mr_s_addr", {32'd0, bus.s_addr}, 64'd0);
        chk("mr_err_valid", {63'd0, bus.err_valid}, 64'd0);
        chk("mr_err_addr", {32'd0, bus.err_addr}, 64'd0);
        chk("mr_rdata", {32'd0, bus.rdata}, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        issue(32'h0000_0804, 1'b0, 32'h0);
        bus.s_ready = 4'b0010;
        expect_resp(1'b0, 32'hDEADBEEF);
        step();
        bus.req = 1'b0;
        step();
        chk("pr_ready", {63'd0, bus.ready}, 64'd1);
        chk("pr_rdata", {32'd0, bus.rdata}, 64'hDEADBEEF);
        step();
        bus.s_ready = '0;
        step();
        step();
        chk("sb_drained", {32'd0, 32'(sb_q.size())}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
